// File: rtl/link_pkg.sv
// Shared types and helpers for the token-ring link monitor.
package link_pkg;

   localparam int unsigned TOKEN_W = 32;

   typedef struct packed {
      logic               wen;
      logic [TOKEN_W-1:0] token;
      logic [TOKEN_W-1:0] clk_cnt;
      logic [TOKEN_W-1:0] id;
   } link_bundle_t;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } mon_state_t;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == '1) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/link_lat_stats.sv
// Per-run latency statistics: running minimum, maximum and saturating sum.
module link_lat_stats
   import link_pkg::*;
#(
   parameter int unsigned SUM_W = 48
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               clr,
   input  logic               upd,
   input  logic [TOKEN_W-1:0] lat,
   output logic [TOKEN_W-1:0] lat_min,
   output logic [TOKEN_W-1:0] lat_max,
   output logic [SUM_W-1:0]   lat_sum
);

   // One extra bit catches the carry out so the sum clamps instead of wrapping.
   logic [SUM_W:0] sum_ext;

   assign sum_ext = {1'b0, lat_sum} + (SUM_W+1)'(lat);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         lat_min <= '1;
         lat_max <= '0;
         lat_sum <= '0;
      end else if (clr) begin
         lat_min <= '1;
         lat_max <= '0;
         lat_sum <= '0;
      end else if (upd) begin
         if (lat < lat_min) lat_min <= lat;
         if (lat > lat_max) lat_max <= lat;
         lat_sum <= sum_ext[SUM_W] ? '1 : sum_ext[SUM_W-1:0];
      end
   end

endmodule

// File: rtl/link_token_monitor.sv
// Last-link monitor: forwards the bundle one cycle late, checks sequence/id,
// measures latency and raises a benchmark event every EVENT_DIV tokens.
module link_token_monitor
   import link_pkg::*;
#(
   parameter logic [31:0] EXP_ID    = 32'd0,
   parameter int unsigned EVENT_DIV = 16,
   parameter int unsigned SUM_W     = 48
) (
   input  logic               i_clk,
   input  logic               i_rstn,
   input  logic               i_wen,
   input  logic [TOKEN_W-1:0] i_token,
   input  logic [TOKEN_W-1:0] i_clk_cnt,
   input  logic [TOKEN_W-1:0] i_id,
   input  logic               i_start,
   input  logic [31:0]        i_n_tokens,
   output logic               o_wen,
   output logic [TOKEN_W-1:0] o_token,
   output logic [TOKEN_W-1:0] o_clk_cnt,
   output logic [TOKEN_W-1:0] o_id,
   output logic               o_benchmark_event,
   output logic               o_busy,
   output logic               o_done,
   output logic [31:0]        o_count,
   output logic [31:0]        o_lat_min,
   output logic [31:0]        o_lat_max,
   output logic [SUM_W-1:0]   o_lat_sum,
   output logic [15:0]        o_seq_err,
   output logic [15:0]        o_id_err
);

   link_bundle_t       in_b;
   link_bundle_t       out_b;
   mon_state_t         state;
   logic [31:0]        cyc_cnt;
   logic [31:0]        target;
   logic [31:0]        count;
   logic [31:0]        div_cnt;
   logic [TOKEN_W-1:0] expected;
   logic [TOKEN_W-1:0] lat;
   logic               first;
   logic               bench_event;
   logic [15:0]        seq_err;
   logic [15:0]        id_err;
   logic               accept;
   logic               begin_run;
   logic               last_tok;

   assign in_b      = '{wen: i_wen, token: i_token, clk_cnt: i_clk_cnt, id: i_id};
   assign accept    = (state == RUN) && i_wen;
   assign begin_run = (state != RUN) && i_start;
   assign lat       = cyc_cnt - i_clk_cnt;
   assign last_tok  = accept && ((count + 32'd1) == target);

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) out_b <= '0;
      else         out_b <= in_b;
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state       <= IDLE;
         cyc_cnt     <= '0;
         target      <= '0;
         count       <= '0;
         div_cnt     <= '0;
         expected    <= '0;
         first       <= 1'b1;
         bench_event <= 1'b0;
         seq_err     <= '0;
         id_err      <= '0;
      end else begin
         cyc_cnt     <= cyc_cnt + 32'd1;
         bench_event <= 1'b0;
         // A start strobe wins over a coincident token: the token is only forwarded.
         if (begin_run) begin
            state   <= RUN;
            count   <= '0;
            div_cnt <= '0;
            seq_err <= '0;
            id_err  <= '0;
            first   <= 1'b1;
            target  <= (i_n_tokens == '0) ? 32'd1 : i_n_tokens;
         end else if (accept) begin
            count <= count + 32'd1;
            if (i_id != EXP_ID) id_err <= sat_inc16(id_err);
            if (!first && (i_token != expected)) seq_err <= sat_inc16(seq_err);
            expected <= i_token + 1'b1;
            first    <= 1'b0;
            if (div_cnt == 32'(EVENT_DIV - 1)) begin
               div_cnt     <= '0;
               bench_event <= 1'b1;
            end else begin
               div_cnt <= div_cnt + 32'd1;
            end
            if (last_tok) state <= DONE;
         end
      end
   end

   link_lat_stats #(
      .SUM_W (SUM_W)
   ) u_stats (
      .clk     (i_clk),
      .rstn    (i_rstn),
      .clr     (begin_run),
      .upd     (accept),
      .lat     (lat),
      .lat_min (o_lat_min),
      .lat_max (o_lat_max),
      .lat_sum (o_lat_sum)
   );

   assign o_wen             = out_b.wen;
   assign o_token           = out_b.token;
   assign o_clk_cnt         = out_b.clk_cnt;
   assign o_id              = out_b.id;
   assign o_benchmark_event = bench_event;
   assign o_busy            = (state == RUN);
   assign o_done            = (state == DONE);
   assign o_count           = count;
   assign o_seq_err         = seq_err;
   assign o_id_err          = id_err;

endmodule

// File: tb/tb_link_token_monitor.sv
// Randomized bench for link_token_monitor against a queue-based run model.
module tb_link_token_monitor;

   localparam logic [31:0] TB_EXP_ID = 32'd0;
   localparam int unsigned TB_DIV    = 16;
   localparam int unsigned TB_SUM_W  = 48;

   logic                i_clk = 1'b0;
   logic                i_rstn = 1'b0;
   logic                i_wen = 1'b0;
   logic [31:0]         i_token = '0;
   logic [31:0]         i_clk_cnt = '0;
   logic [31:0]         i_id = '0;
   logic                i_start = 1'b0;
   logic [31:0]         i_n_tokens = '0;
   logic                o_wen;
   logic [31:0]         o_token;
   logic [31:0]         o_clk_cnt;
   logic [31:0]         o_id;
   logic                o_benchmark_event;
   logic                o_busy;
   logic                o_done;
   logic [31:0]         o_count;
   logic [31:0]         o_lat_min;
   logic [31:0]         o_lat_max;
   logic [TB_SUM_W-1:0] o_lat_sum;
   logic [15:0]         o_seq_err;
   logic [15:0]         o_id_err;

   link_token_monitor #(
      .EXP_ID    (TB_EXP_ID),
      .EVENT_DIV (TB_DIV),
      .SUM_W     (TB_SUM_W)
   ) dut (
      .i_clk             (i_clk),
      .i_rstn            (i_rstn),
      .i_wen             (i_wen),
      .i_token           (i_token),
      .i_clk_cnt         (i_clk_cnt),
      .i_id              (i_id),
      .i_start           (i_start),
      .i_n_tokens        (i_n_tokens),
      .o_wen             (o_wen),
      .o_token           (o_token),
      .o_clk_cnt         (o_clk_cnt),
      .o_id              (o_id),
      .o_benchmark_event (o_benchmark_event),
      .o_busy            (o_busy),
      .o_done            (o_done),
      .o_count           (o_count),
      .o_lat_min         (o_lat_min),
      .o_lat_max         (o_lat_max),
      .o_lat_sum         (o_lat_sum),
      .o_seq_err         (o_seq_err),
      .o_id_err          (o_id_err)
   );

   always #5 i_clk = ~i_clk;

   typedef enum {M_IDLE, M_RUN, M_DONE} ref_state_t;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;
   int unsigned ev_seen = 0;
   logic [31:0] tb_cyc  = '0;
   ref_state_t  m_state = M_IDLE;
   logic [31:0] m_target = '0;
   logic [31:0] q_lat[$];
   logic [31:0] q_tok[$];
   logic [31:0] q_id[$];

   // Cycles elapsed since reset release, i.e. the value the monitor stamps against.
   always @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) tb_cyc = '0;
      else         tb_cyc = tb_cyc + 32'd1;
   end

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      q_lat.delete();
      q_tok.delete();
      q_id.delete();
   endtask

   // Drives one cycle of inputs right after a falling edge, checks one cycle later.
   task automatic step(input logic wen, input logic [31:0] tok, input logic [31:0] ccnt,
                       input logic [31:0] id, input logic start, input logic [31:0] n);
      logic exp_ev;
      exp_ev     = 1'b0;
      i_wen      = wen;
      i_token    = tok;
      i_clk_cnt  = ccnt;
      i_id       = id;
      i_start    = start;
      i_n_tokens = n;
      if (m_state != M_RUN && start) begin
         model_clear();
         m_target = (n == 0) ? 32'd1 : n;
         m_state  = M_RUN;
      end else if (m_state == M_RUN && wen) begin
         q_lat.push_back(tb_cyc - ccnt);
         q_tok.push_back(tok);
         q_id.push_back(id);
         if (q_lat.size() % TB_DIV == 0) exp_ev = 1'b1;
         if (q_lat.size() == m_target) m_state = M_DONE;
      end
      @(negedge i_clk);
      check_eq("pass_wen", 64'(o_wen), 64'(wen));
      check_eq("pass_token", 64'(o_token), 64'(tok));
      check_eq("pass_clk_cnt", 64'(o_clk_cnt), 64'(ccnt));
      check_eq("pass_id", 64'(o_id), 64'(id));
      check_eq("event", 64'(o_benchmark_event), 64'(exp_ev));
      check_eq("busy", 64'(o_busy), 64'(m_state == M_RUN));
      check_eq("done", 64'(o_done), 64'(m_state == M_DONE));
      check_eq("count", 64'(o_count), 64'(q_lat.size()));
      if (o_benchmark_event) ev_seen++;
      i_wen   = 1'b0;
      i_start = 1'b0;
   endtask

   task automatic send(input logic [31:0] tok, input logic [31:0] lat, input logic [31:0] id);
      step(1'b1, tok, tb_cyc - lat, id, 1'b0, 32'd0);
   endtask

   task automatic idle();
      step(1'b0, $urandom, $urandom, $urandom, 1'b0, 32'd0);
   endtask

   task automatic check_stats(input string tag);
      logic [31:0] mn;
      logic [31:0] mx;
      logic [63:0] sm;
      int unsigned se;
      int unsigned ie;
      mn = 32'hFFFF_FFFF;
      mx = '0;
      sm = '0;
      se = 0;
      ie = 0;
      foreach (q_lat[i]) begin
         if (q_lat[i] < mn) mn = q_lat[i];
         if (q_lat[i] > mx) mx = q_lat[i];
         sm += 64'(q_lat[i]);
         if (q_id[i] != TB_EXP_ID) ie++;
         if (i > 0 && q_tok[i] != q_tok[i-1] + 32'd1) se++;
      end
      if (sm > 64'hFFFF_FFFF_FFFF) sm = 64'hFFFF_FFFF_FFFF;
      check_eq({tag, "_count"}, 64'(o_count), 64'(q_lat.size()));
      check_eq({tag, "_min"}, 64'(o_lat_min), 64'(mn));
      check_eq({tag, "_max"}, 64'(o_lat_max), 64'(mx));
      check_eq({tag, "_sum"}, 64'(o_lat_sum), sm);
      check_eq({tag, "_seq_err"}, 64'(o_seq_err), 64'(se));
      check_eq({tag, "_id_err"}, 64'(o_id_err), 64'(ie));
   endtask

   task automatic check_reset(input string tag);
      check_eq({tag, "_wen"}, 64'(o_wen), 64'd0);
      check_eq({tag, "_token"}, 64'(o_token), 64'd0);
      check_eq({tag, "_clk_cnt"}, 64'(o_clk_cnt), 64'd0);
      check_eq({tag, "_id"}, 64'(o_id), 64'd0);
      check_eq({tag, "_event"}, 64'(o_benchmark_event), 64'd0);
      check_eq({tag, "_busy"}, 64'(o_busy), 64'd0);
      check_eq({tag, "_done"}, 64'(o_done), 64'd0);
      check_eq({tag, "_count"}, 64'(o_count), 64'd0);
      check_eq({tag, "_min"}, 64'(o_lat_min), 64'hFFFF_FFFF);
      check_eq({tag, "_max"}, 64'(o_lat_max), 64'd0);
      check_eq({tag, "_sum"}, 64'(o_lat_sum), 64'd0);
      check_eq({tag, "_seq_err"}, 64'(o_seq_err), 64'd0);
      check_eq({tag, "_id_err"}, 64'(o_id_err), 64'd0);
   endtask

   // Asynchronous reset asserted mid-cycle, released just after a falling edge.
   task automatic do_reset(input string tag);
      #2;
      i_rstn = 1'b0;
      #1;
      check_reset(tag);
      model_clear();
      m_state = M_IDLE;
      @(negedge i_clk);
      @(negedge i_clk);
      #1;
      i_rstn = 1'b1;
   endtask

   task automatic run_random(input string tag);
      logic [31:0] n;
      logic [31:0] tok;
      logic [31:0] lat;
      n   = $urandom_range(0, 12);
      tok = $urandom;
      step(1'b0, '0, '0, '0, 1'b1, n);
      for (int k = 0; k < 200 && m_state == M_RUN; k++) begin
         if ($urandom_range(0, 3) == 0) begin
            idle();
         end else begin
            lat = ($urandom_range(0, 7) == 0) ? $urandom : $urandom_range(0, 50);
            send(tok, lat, ($urandom_range(0, 5) == 0) ? 32'd7 : TB_EXP_ID);
            tok = ($urandom_range(0, 4) == 0) ? $urandom : tok + 32'd1;
         end
      end
      check_stats(tag);
      send(tok, 32'd1, 32'd9);
      send(tok + 32'd1, 32'd2, TB_EXP_ID);
      check_stats({tag, "_held"});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
      $fatal(1);
   end

   initial begin
      repeat (3) @(negedge i_clk);
      check_reset("por");
      #1;
      i_rstn = 1'b1;

      for (int k = 0; k < 4; k++) step(k[0], 32'd5, $urandom, $urandom, 1'b0, 32'd0);
      check_stats("idle");

      step(1'b0, '0, '0, '0, 1'b1, 32'd4);
      for (int k = 0; k < 4; k++) send(32'd10 + 32'(k), 32'd7, TB_EXP_ID);
      check_eq("basic_sum28", 64'(o_lat_sum), 64'd28);
      check_stats("basic");
      send(32'd14, 32'd3, TB_EXP_ID);
      check_stats("basic_held");

      step(1'b0, '0, '0, '0, 1'b1, 32'd4);
      send(32'd1, 32'd3, TB_EXP_ID);
      send(32'd2, 32'd4, TB_EXP_ID);
      send(32'd5, 32'd5, TB_EXP_ID);
      send(32'd6, 32'd6, TB_EXP_ID);
      check_eq("gap_seq_err1", 64'(o_seq_err), 64'd1);
      check_stats("gap");

      step(1'b0, '0, '0, '0, 1'b1, 32'd4);
      send(32'd20, 32'd2, TB_EXP_ID);
      send(32'd21, 32'd2, 32'd3);
      send(32'd22, 32'd2, TB_EXP_ID);
      send(32'd23, 32'd2, TB_EXP_ID);
      check_eq("id_err1", 64'(o_id_err), 64'd1);
      check_stats("idmis");

      ev_seen = 0;
      step(1'b1, 32'd99, tb_cyc - 32'd3, TB_EXP_ID, 1'b1, 32'd40);
      begin
         logic [31:0] tok;
         tok = 32'd100;
         for (int k = 0; k < 400 && m_state == M_RUN; k++) begin
            if ($urandom_range(0, 3) == 0) idle();
            else begin
               send(tok, $urandom_range(1, 30), TB_EXP_ID);
               tok++;
            end
         end
      end
      for (int k = 0; k < 3; k++) send(32'd500, 32'd1, TB_EXP_ID);
      check_eq("event_pulses", 64'(ev_seen), 64'd2);
      check_stats("ev40");

      for (int r = 0; r < 6; r++) run_random($sformatf("rnd%0d", r));

      step(1'b0, '0, '0, '0, 1'b1, 32'd4);
      send(32'd30, 32'd5, TB_EXP_ID);
      send(32'd31, 32'd5, TB_EXP_ID);
      do_reset("midrun");
      step(1'b0, '0, '0, '0, 1'b1, 32'd4);
      for (int k = 0; k < 4; k++) send(32'd40 + 32'(k), 32'd9, TB_EXP_ID);
      check_stats("after_rst");

      do_reset("pre_wrap");
      idle();
      step(1'b0, '0, '0, '0, 1'b1, 32'd1);
      step(1'b1, 32'd77, 32'hFFFF_FFFE, TB_EXP_ID, 1'b0, 32'd0);
      check_eq("wrap_lat4", 64'(o_lat_max), 64'd4);
      check_stats("wrap");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/link_token_monitor.md
Name: link_token_monitor

Overview:
- Downstream stage of the last link in the token ring; consumes that link's output bundle (wen/token/clk_cnt/id).
- Forwards the bundle with one register of delay to the next consumer (anchor interface or benchmark pin).
- Measures per-token latency, checks token sequence and id, and emits a benchmark event pulse.
- Run control: armed by a start strobe; completes after a programmed number of tokens.

Parameters:
- EXP_ID, 0, id value every received token must carry
- EVENT_DIV, 16, accepted tokens per o_benchmark_event pulse (>=1)
- SUM_W, 48, width of the latency accumulator

Ports:
- i_clk  in  1  clock
- i_rstn  in  1  reset, asynchronous, active-low
- i_wen  in  1  token valid from upstream link
- i_token  in  32  token value
- i_clk_cnt  in  32  cycle stamp written by the token originator
- i_id  in  32  originator id
- i_start  in  1  one-cycle run start strobe
- i_n_tokens  in  32  tokens per run; 0 is treated as 1
- o_wen  out  1  registered i_wen
- o_token  out  32  registered i_token
- o_clk_cnt  out  32  registered i_clk_cnt
- o_id  out  32  registered i_id
- o_benchmark_event  out  1  one-cycle pulse every EVENT_DIV accepted tokens
- o_busy  out  1  state == RUN
- o_done  out  1  state == DONE
- o_count  out  32  accepted tokens this run
- o_lat_min  out  32  minimum latency
- o_lat_max  out  32  maximum latency
- o_lat_sum  out  SUM_W  latency sum, saturating
- o_seq_err  out  16  sequence mismatches, saturating
- o_id_err  out  16  id mismatches, saturating

Behaviour:
- Reset (async, i_rstn=0):
  - All outputs 0, except o_lat_min = 32'hFFFF_FFFF.
  - State IDLE; cycle counter 0; expected token 0; first-flag 1.
- Pass-through:
  - o_wen/o_token/o_clk_cnt/o_id <= inputs every cycle, in every state.
  - Latency exactly 1 cycle; no backpressure.
- Cycle counter: 32-bit, free-running, +1 per cycle, wraps mod 2^32.
- Latency: lat = cyc_cnt - i_clk_cnt mod 2^32, sampled in the same cycle i_wen=1.
- FSM states: IDLE, RUN, DONE.
  - IDLE or DONE with i_start=1 -> RUN. Same cycle: clear count, sum, errors, and the event divider; set min=FFFF_FFFF, max=0, first-flag=1; latch target = max(i_n_tokens,1).
  - An i_wen coincident with i_start is forwarded but not accepted.
  - RUN: each i_wen=1 is accepted:
    - count++; min/max updated; sum += lat, saturating at all-ones.
    - If i_id != EXP_ID: id_err++ (saturating at FFFF); the token is still accepted.
    - If first-flag=0 and i_token != expected: seq_err++ (saturating). Either way expected <= i_token+1 (wraps) and first-flag <= 0.
  - RUN: i_start is ignored.
  - RUN: the accepted token that makes count == target -> DONE next cycle. Stats include that token; tokens in later cycles are not accepted.
  - DONE: stats held stable until the next i_start.
- Event divider:
  - Counts accepted tokens 0..EVENT_DIV-1.
  - On wrap, o_benchmark_event = 1 for exactly one cycle, registered (asserted the cycle after the accepting edge).
  - Never pulses in IDLE or DONE.
- Reset mid-run: returns immediately to reset values; no partial stats are retained.

Decomposition:
- Shared package link_pkg:
  - TOKEN_W=32
  - typedef link_bundle_t {wen, token, clk_cnt, id}
  - enum mon_state_t {IDLE, RUN, DONE}
  - saturating-increment function
- One sub-module: link_lat_stats, holding the min/max/saturating-sum datapath with clear and update strobes.
- FSM, sequence/id check and divider stay in the top module.

Test Plan:
- Reset then idle traffic: i_wen pulses with token=5 -> o_* mirror inputs 1 cycle later; o_count=0; o_busy=0; no event pulse.
- Start with i_n_tokens=4, EXP_ID=0, tokens 10,11,12,13, each with clk_cnt = cyc_cnt-7 -> count=4, min=max=7, sum=28, seq_err=0, o_done=1 the cycle after the 4th token.
- Sequence gap: tokens 1,2,5,6 -> seq_err=1 (resync at 5).
- Id mismatch: token id=3 -> id_err=1, count=4; counter wrap case with cyc_cnt=2, clk_cnt=FFFF_FFFE -> lat=4.
- EVENT_DIV=16, i_n_tokens=40 -> exactly 2 o_benchmark_event pulses, each 1 cycle wide; i_start coincident with i_wen -> that token not counted.
- Reset asserted after 2 of 4 tokens -> all stats at reset values, state IDLE; new start then 4 tokens -> normal completion.
